// File: rtl/gj_axis_uart_pkg.sv
// ============================================================================
// Module  : gj_axis_uart_pkg
// Brief   : Shared types and constants for the AXIS UART transmit path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gj_axis_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_DONE = 3'd2,
    BYTE_GAP  = 3'd3,
    FRAME_GAP = 3'd4
  } state_e;

  localparam int MODE_TXNOP_BIT = 3;
  localparam int X16_PER_BIT    = 16;
  localparam int TIMEOUT_BITS   = 16;

endpackage

`default_nettype wire

// File: rtl/gj_uart_bit_timer.sv
// ============================================================================
// Module  : gj_uart_bit_timer
// Brief   : Counts a latched number of bit times (16 x16 ticks each) and
//           pulses o_done on the last clock of the interval.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gj_uart_bit_timer
  import gj_axis_uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int NOP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_clk_div,
  input  logic [NOP_W-1:0] i_nbits,
  output logic             o_done
);

  localparam int X16_W = $clog2(X16_PER_BIT);

  logic [DIV_W-1:0] r_div;
  logic [X16_W-1:0] r_tick;
  logic [NOP_W-1:0] r_bits;
  logic [NOP_W-1:0] r_nbits;
  logic [DIV_W-1:0] w_div_last;
  logic             w_tick;
  logic             w_bit_end;

  // A divider of 0 behaves as 1 so the tick never stalls.
  assign w_div_last = (i_clk_div == '0) ? '0 : i_clk_div - DIV_W'(1);
  assign w_tick     = (r_div >= w_div_last);
  assign w_bit_end  = w_tick && (r_tick == X16_W'(X16_PER_BIT - 1));
  assign o_done     = i_run && !i_start && w_bit_end &&
                      (r_bits >= r_nbits - NOP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_tick  <= '0;
      r_bits  <= '0;
      r_nbits <= '0;
    end else if (i_start) begin
      r_div   <= '0;
      r_tick  <= '0;
      r_bits  <= '0;
      r_nbits <= i_nbits;
    end else if (i_run) begin
      if (w_tick) begin
        r_div  <= '0;
        r_tick <= r_tick + X16_W'(1);
        if (w_bit_end) begin
          r_bits <= r_bits + NOP_W'(1);
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gj_axis_uart_tx_sched.sv
// ============================================================================
// Module  : gj_axis_uart_tx_sched
// Brief   : Transmit scheduler between AXIS byte input and the UART bit
//           serializer, with optional programmable inter-byte/frame gaps.
//           Optional macro GJ_TX_SCHED_TIMEOUT_EN adds the txTimeout output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gj_axis_uart_tx_sched
  import gj_axis_uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int NOP_W = 16,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             powerDown,
  input  logic             softRst,
  input  logic [3:0]       mode,
  input  logic [DIV_W-1:0] clkDivX16,
  input  logic [NOP_W-1:0] txByte_nop,
  input  logic [NOP_W-1:0] txFrame_nop,
  input  logic [CNT_W-1:0] maxBytesPerFrame,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [7:0]       ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  input  logic             ser_done,
  output logic             txBytesInt,
  output logic             busy
`ifdef GJ_TX_SCHED_TIMEOUT_EN
  ,
  output logic             txTimeout
`endif
);

  state_e           r_state;
  state_e           w_next;
  logic [7:0]       r_data;
  logic             r_last;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_bytes_int;
  logic             w_accept;
  logic             w_byte_done;
  logic             w_frame_end;
  logic             w_nop_en;
  logic             w_tmr_start;
  logic             w_tmr_run;
  logic             w_tmr_done;
  logic [NOP_W-1:0] w_tmr_nbits;
  logic             w_unused_mode;
`ifdef GJ_TX_SCHED_TIMEOUT_EN
  logic             r_timeout;
  logic             w_timeout;
`endif

  assign w_unused_mode = ^mode[2:0];
  assign w_nop_en      = mode[MODE_TXNOP_BIT];
  assign s_tready      = rst_n && (r_state == IDLE) && !powerDown;
  assign ser_valid     = (r_state == SEND);
  assign busy          = (r_state != IDLE);
  assign ser_data      = r_data;
  assign txBytesInt    = r_bytes_int;
  // Equality only: lowering the limit below the count defers to s_tlast.
  assign w_frame_end   = r_last || ((maxBytesPerFrame != '0) &&
                         (r_byte_cnt + CNT_W'(1) == maxBytesPerFrame));

`ifdef GJ_TX_SCHED_TIMEOUT_EN
  assign txTimeout = r_timeout;
  assign w_tmr_run = (r_state == BYTE_GAP) || (r_state == FRAME_GAP) ||
                     (r_state == WAIT_DONE);
`else
  assign w_tmr_run = (r_state == BYTE_GAP) || (r_state == FRAME_GAP);
`endif

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_byte_done = 1'b0;
    w_tmr_start = 1'b0;
    w_tmr_nbits = NOP_W'(TIMEOUT_BITS);
`ifdef GJ_TX_SCHED_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (s_tvalid && s_tready) begin
          w_accept = 1'b1;
          w_next   = SEND;
        end
      end
      SEND: begin
        if (ser_ready) begin
          w_next = WAIT_DONE;
`ifdef GJ_TX_SCHED_TIMEOUT_EN
          w_tmr_start = 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (ser_done) begin
          w_byte_done = 1'b1;
          w_next      = IDLE;
          if (w_frame_end) begin
            if (w_nop_en && (txFrame_nop != '0)) begin
              w_next      = FRAME_GAP;
              w_tmr_start = 1'b1;
              w_tmr_nbits = txFrame_nop;
            end
          end else if (w_nop_en && (txByte_nop != '0)) begin
            w_next      = BYTE_GAP;
            w_tmr_start = 1'b1;
            w_tmr_nbits = txByte_nop;
          end
        end
`ifdef GJ_TX_SCHED_TIMEOUT_EN
        else if (w_tmr_done) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
`endif
      end
      BYTE_GAP, FRAME_GAP: begin
        if (w_tmr_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_byte_cnt  <= '0;
      r_bytes_int <= 1'b0;
`ifdef GJ_TX_SCHED_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else if (softRst) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_bytes_int <= 1'b0;
`ifdef GJ_TX_SCHED_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_bytes_int <= w_byte_done;
`ifdef GJ_TX_SCHED_TIMEOUT_EN
      r_timeout   <= w_timeout;
`endif
      if (w_accept) begin
        r_data <= s_tdata;
        r_last <= s_tlast;
      end
      if (w_byte_done) begin
        r_byte_cnt <= w_frame_end ? '0 : r_byte_cnt + CNT_W'(1);
      end
    end
  end

  gj_uart_bit_timer #(
    .DIV_W (DIV_W),
    .NOP_W (NOP_W)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_tmr_start),
    .i_run     (w_tmr_run),
    .i_clk_div (clkDivX16),
    .i_nbits   (w_tmr_nbits),
    .o_done    (w_tmr_done)
  );

endmodule

`default_nettype wire
